// File: rtl/trap_ctrl_pkg.sv
// Types and constants shared by the trap controller and its users.
// Offsets and addresses come from common.vh so the core and controller agree.
package trap_ctrl_pkg;

`include "common.vh"

    localparam logic [31:0] TC_TRAP_ADDR = `TRAP_ADDR;
    localparam logic [31:0] TC_BASE_ADDR = `TC_BASE;
    localparam logic [3:0]  CAUSE_NONE   = 4'hF;

    typedef enum logic [2:0] {
        REG_PENDING = `TC_PENDING,
        REG_MASK    = `TC_MASK,
        REG_CAUSE   = `TC_CAUSE,
        REG_EPC     = `TC_EPC,
        REG_IE      = `TC_IE
    } reg_off_e;

    // Index of the lowest set bit; 0 when nothing is set (caller checks).
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) res = 4'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/common.vh
// Shared address map for the core and its memory-mapped peripherals.
`ifndef COMMON_VH
`define COMMON_VH

`define TRAP_ADDR   32'h0000_0010

`define TC_PENDING  3'd0
`define TC_MASK     3'd1
`define TC_CAUSE    3'd2
`define TC_EPC      3'd3
`define TC_IE       3'd4

`define TC_BASE     32'hFFFF_FF00

`endif

// File: rtl/trap_ctrl_irq_sync.sv
// Two-flop synchronizer plus rising-edge detector for one async irq line.
// Latency: edge pulse valid in the cycle after the second sync stage captures.
// Backpressure: none; one single-cycle pulse per rising edge.
module irq_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_a,
    output logic pulse
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= irq_a;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign pulse = s2_q & ~s3_q;

endmodule

// File: rtl/trap_ctrl.sv
// Interrupt/trap controller: pending/mask/IE registers, trap request, EPC/CAUSE capture.
// Latency: irq edge -> PENDING 3 edges, trap 1 edge later; register reads combinational.
// Backpressure: none; bus accesses complete in their strobe cycle.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int          NIRQ = 8,
    parameter logic [31:0] BASE = TC_BASE_ADDR
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NIRQ-1:0] irq,
    output logic            trap,
    input  logic            strobe,
    input  logic            mem_rw,
    input  logic [31:0]     d_addr,
    input  logic [31:0]     d_wdata,
    output logic [31:0]     d_rdata,
    output logic            d_hit
);

    logic [NIRQ-1:0] irq_edge;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] mask_q;
    logic [NIRQ-1:0] active;
    logic [NIRQ-1:0] sel_oh;
    logic [3:0]      sel;
    logic [3:0]      cause_q;
    logic [31:0]     epc_q;
    logic            ie_q;
    logic            trap_q;
    logic            any_act;
    logic            in_win;
    logic            save;
    logic            wr_en;
    reg_off_e        off;

    for (genvar g = 0; g < NIRQ; g++) begin : g_sync
        irq_sync u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .irq_a   (irq[g]),
            .pulse   (irq_edge[g])
        );
    end

    assign in_win = (d_addr[31:3] == BASE[31:3]);
    assign off    = reg_off_e'(d_addr[2:0]);
    // The trap-save store is never a window write, even when it aliases into the window.
    assign save   = strobe & mem_rw & (d_addr == TC_TRAP_ADDR);
    assign wr_en  = strobe & mem_rw & in_win & ~save;
    assign d_hit  = strobe & ~mem_rw & in_win;

    assign active  = pending_q & mask_q;
    assign any_act = |active;
    assign sel     = lowest_idx(16'(active));
    assign sel_oh  = active & (~active + NIRQ'(1));

    // Clears first, then new edges, so a fresh edge always survives a same-cycle clear.
    always_comb begin
        pending_d = pending_q;
        if (wr_en && off == REG_PENDING) pending_d = pending_d & ~d_wdata[NIRQ-1:0];
        if (save) pending_d = pending_d & ~sel_oh;
        pending_d = pending_d | irq_edge;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            mask_q    <= '0;
            cause_q   <= 4'd0;
            epc_q     <= 32'd0;
            ie_q      <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            trap_q    <= ie_q & any_act & ~save;
            if (wr_en && off == REG_MASK) mask_q <= d_wdata[NIRQ-1:0];
            if (save) begin
                ie_q    <= 1'b0;
                epc_q   <= d_wdata;
                cause_q <= any_act ? sel : CAUSE_NONE;
            end else if (wr_en && off == REG_IE) begin
                ie_q <= d_wdata[0];
            end
        end
    end

    always_comb begin
        d_rdata = 32'd0;
        if (d_hit) begin
            case (off)
                REG_PENDING: d_rdata = 32'(pending_q);
                REG_MASK:    d_rdata = 32'(mask_q);
                REG_CAUSE:   d_rdata = 32'(cause_q);
                REG_EPC:     d_rdata = epc_q;
                REG_IE:      d_rdata = 32'(ie_q);
                default:     d_rdata = 32'd0;
            endcase
        end
    end

    assign trap = trap_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed and randomized checks of trap_ctrl against a cycle-level reference model.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam logic [31:0] BASE = TC_BASE_ADDR;
    localparam logic [31:0] TRAP = TC_TRAP_ADDR;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  irq;
    logic        trap;
    logic        strobe;
    logic        mem_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_hit;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: architectural registers plus irq samples taken at previous edges.
    logic [7:0]  m_pend, m_mask;
    logic [3:0]  m_cause;
    logic [31:0] m_epc;
    logic        m_ie, m_trap;
    logic [7:0]  samp [3];

    trap_ctrl #(.NIRQ(8), .BASE(BASE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .irq     (irq),
        .trap    (trap),
        .strobe  (strobe),
        .mem_rw  (mem_rw),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_hit   (d_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_cause = 0; m_epc = 0; m_ie = 0; m_trap = 0;
        for (int i = 0; i < 3; i++) samp[i] = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return {24'd0, m_pend};
            3'd1:    return {24'd0, m_mask};
            3'd2:    return {28'd0, m_cause};
            3'd3:    return m_epc;
            3'd4:    return {31'd0, m_ie};
            default: return 32'd0;
        endcase
    endfunction

    // Applies one clock edge to the model using the inputs currently on the bus.
    task automatic model_edge();
        logic [7:0] ev, act, np;
        logic       sv, wr, in_win;
        int         lowest;
        ev     = samp[1] & ~samp[2];
        act    = m_pend & m_mask;
        in_win = (d_addr[31:3] == BASE[31:3]);
        sv     = strobe && mem_rw && (d_addr == TRAP);
        wr     = strobe && mem_rw && in_win && !sv;
        lowest = -1;
        for (int i = 0; i < 8; i++) if (act[i] && lowest < 0) lowest = i;
        m_trap = m_ie && (act != 0) && !sv;
        np = m_pend;
        if (wr && d_addr[2:0] == 3'd0) np = np & ~d_wdata[7:0];
        if (sv && lowest >= 0) np[lowest] = 1'b0;
        np = np | ev;
        if (wr && d_addr[2:0] == 3'd1) m_mask = d_wdata[7:0];
        if (sv) begin
            m_ie    = 1'b0;
            m_epc   = d_wdata;
            m_cause = (lowest >= 0) ? 4'(lowest) : 4'hF;
        end else if (wr && d_addr[2:0] == 3'd4) begin
            m_ie = d_wdata[0];
        end
        m_pend  = np;
        samp[2] = samp[1];
        samp[1] = samp[0];
        samp[0] = irq;
    endtask

    task automatic cycle();
        logic hit;
        #1;
        hit = strobe && !mem_rw && (d_addr[31:3] == BASE[31:3]);
        chk("d_hit", d_hit, hit);
        chk("d_rdata", d_rdata, hit ? model_read(d_addr[2:0]) : 32'd0);
        @(posedge clk);
        model_edge();
        #1;
        chk("trap", trap, m_trap);
    endtask

    task automatic set_bus(input logic s, input logic rw, input logic [31:0] a, input logic [31:0] wd);
        strobe = s; mem_rw = rw; d_addr = a; d_wdata = wd;
    endtask

    task automatic idle(input int n);
        set_bus(0, 0, 32'd0, 32'd0);
        repeat (n) cycle();
    endtask

    task automatic bus_rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
        set_bus(1, 0, BASE + 32'(off), 32'd0);
        #1 chk(tag, d_rdata, exp);
        cycle();
        set_bus(0, 0, 32'd0, 32'd0);
    endtask

    task automatic bus_wr(input logic [2:0] off, input logic [31:0] data);
        set_bus(1, 1, BASE + 32'(off), data);
        cycle();
        set_bus(0, 0, 32'd0, 32'd0);
    endtask

    task automatic save(input logic [31:0] pc);
        set_bus(1, 1, TRAP, pc);
        cycle();
        set_bus(0, 0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        reset_n = 1'b0;
        irq = 8'd0;
        set_bus(0, 0, 32'd0, 32'd0);
        model_reset();
        #12 reset_n = 1'b1;

        // Reset state
        chk("trap_rst", trap, 0);
        for (int i = 0; i < 5; i++) bus_rd($sformatf("rst_off%0d", i), 3'(i), 32'd0);
        set_bus(1, 0, BASE + 32'd6, 32'd0);
        #1 chk("hit_off6", d_hit, 1);
        chk("rd_off6", d_rdata, 0);
        cycle();

        // Single interrupt and save
        bus_wr(3'd1, 32'h04);
        bus_wr(3'd4, 32'h1);
        irq[2] = 1'b1;
        idle(2);
        irq[2] = 1'b0;
        idle(1);
        bus_rd("pend_E3", 3'd0, 32'h04);
        chk("trap_E4", trap, 1);
        save(32'h0000_0123);
        chk("trap_after_save", trap, 0);
        bus_rd("epc", 3'd3, 32'h123);
        bus_rd("cause2", 3'd2, 32'd2);
        bus_rd("pend_clr", 3'd0, 32'd0);
        bus_rd("ie_clr", 3'd4, 32'd0);

        // Two simultaneous interrupts, priority and re-enable
        bus_wr(3'd1, 32'hFF);
        bus_wr(3'd4, 32'h1);
        irq = 8'h22;
        idle(2);
        irq = 8'h00;
        idle(2);
        chk("trap_two", trap, 1);
        save(32'h200);
        chk("trap_save2", trap, 0);
        bus_rd("cause1", 3'd2, 32'd1);
        bus_rd("pend_20", 3'd0, 32'h20);
        idle(2);
        chk("trap_held_low", trap, 0);
        bus_wr(3'd4, 32'h1);
        idle(1);
        chk("trap_reen", trap, 1);
        save(32'h300);
        bus_rd("cause5", 3'd2, 32'd5);

        // Empty save reports no cause and leaves PENDING alone
        save(32'h400);
        bus_rd("cause_none", 3'd2, 32'hF);

        // New edge beats W1C on the same edge
        irq[0] = 1'b1;
        idle(2);
        irq[0] = 1'b0;
        idle(2);
        irq[0] = 1'b1;
        idle(2);
        bus_wr(3'd0, 32'h01);
        irq[0] = 1'b0;
        bus_rd("w1c_race", 3'd0, 32'h01);

        // Asynchronous reset mid-cycle
        bus_wr(3'd4, 32'h1);
        idle(1);
        chk("trap_pre_rst", trap, 1);
        #2 reset_n = 1'b0;
        #1 chk("trap_async_rst", trap, 0);
        for (int i = 0; i < 5; i++) begin
            set_bus(1, 0, BASE + 32'(i), 32'd0);
            #1 chk($sformatf("async_rst_off%0d", i), d_rdata, 32'd0);
        end
        set_bus(0, 0, 32'd0, 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
            r = $urandom;
            case ($urandom_range(0, 15))
                0, 1, 2, 3:  set_bus(0, 0, 32'd0, r);
                4:           set_bus(1, 1, TRAP, r);
                5:           set_bus(1, $urandom_range(0, 1), $urandom, r);
                6:           set_bus(1, 1, BASE + 32'd4, {31'd0, 1'b1});
                default:     set_bus(1, $urandom_range(0, 1), BASE + 32'($urandom_range(0, 7)), r);
            endcase
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
